// File: rtl/dmem_arbiter_pkg.sv
// Shared types, constants and the address window check for the data memory arbiter.
package dmem_arb_pkg;

    localparam logic [31:0] DMEM_BASE  = 32'd1024;
    localparam logic [31:0] DMEM_WORDS = 32'd64;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Transaction captured from the winning requester at grant time.
    typedef struct packed {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // True when addr is word aligned and inside [base, base + 4*words).
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base  = DMEM_BASE,
        input logic [31:0] words = DMEM_WORDS
    );
        logic [31:0] upper;
        upper = base + (words << 2);
        return (addr >= base) && (addr < upper) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes and memory-side bus of the data memory arbiter.
interface dmem_arbiter_if;

    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ready0;
    logic        err0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ready1;
    logic        err1;

    logic [31:0] rdata;

    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ready0, err0, ready1, err1, rdata,
        output mem_adr, mem_wdata, mem_read, mem_write
    );

    // Requester / memory side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ready0, err0, ready1, err1, rdata,
        input  mem_adr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on contention the side not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        unique case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the word-addressed data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter logic [31:0] WORD_COUNT  = DMEM_WORDS,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    dmem_req_t          req_q, req_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               grant_valid;
    logic               grant_id;
    dmem_req_t          cand;

    rr_arb2 u_rr_arb2 (
        .req         ({bus.req1, bus.req0}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        cand = '0;
        cand.id = grant_id;
        if (grant_id) begin
            cand.we    = bus.we1;
            cand.addr  = bus.addr1;
            cand.wdata = bus.wdata1;
        end else begin
            cand.we    = bus.we0;
            cand.addr  = bus.addr0;
            cand.wdata = bus.wdata0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_q        <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_d = cand;
                    // Bad addresses skip ACCESS entirely so no strobe ever reaches the memory.
                    if (!in_range(cand.addr, BASE_ADDR, WORD_COUNT)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!req_q.we) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_grant_d = req_q.id;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from registered state so reset clears them asynchronously.
    assign bus.mem_adr   = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_read  = (state_q == ACCESS) && !req_q.we;
    assign bus.mem_write = (state_q == ACCESS) && req_q.we && (cnt_q == '0);

    assign bus.ready0 = (state_q == DONE) && !req_q.id;
    assign bus.ready1 = (state_q == DONE) &&  req_q.id;
    assign bus.err0   = bus.ready0 && err_q;
    assign bus.err1   = bus.ready1 && err_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (WAIT_CYCLES 1, 3, 0) with a negedge-write memory model each.
module tb_dmem_arbiter;

    localparam int WCS [3] = '{1, 3, 0};

    logic clk;
    logic rst;

    logic        req0_i [3];
    logic        we0_i [3];
    logic [31:0] addr0_i [3];
    logic [31:0] wdata0_i [3];
    logic        req1_i [3];
    logic        we1_i [3];
    logic [31:0] addr1_i [3];
    logic [31:0] wdata1_i [3];

    logic        ready0_o [3];
    logic        err0_o [3];
    logic        ready1_o [3];
    logic        err1_o [3];
    logic [31:0] rdata_o [3];
    logic [31:0] mem_adr_o [3];
    logic [31:0] mem_wdata_o [3];
    logic        mem_read_o [3];
    logic        mem_write_o [3];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        dmem_arbiter_if bus ();
        logic [31:0] mem [64];
        logic [5:0]  idx;

        dmem_arbiter #(.WAIT_CYCLES(WCS[g])) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.req0   = req0_i[g];
        assign bus.we0    = we0_i[g];
        assign bus.addr0  = addr0_i[g];
        assign bus.wdata0 = wdata0_i[g];
        assign bus.req1   = req1_i[g];
        assign bus.we1    = we1_i[g];
        assign bus.addr1  = addr1_i[g];
        assign bus.wdata1 = wdata1_i[g];

        assign ready0_o[g]    = bus.ready0;
        assign err0_o[g]      = bus.err0;
        assign ready1_o[g]    = bus.ready1;
        assign err1_o[g]      = bus.err1;
        assign rdata_o[g]     = bus.rdata;
        assign mem_adr_o[g]   = bus.mem_adr;
        assign mem_wdata_o[g] = bus.mem_wdata;
        assign mem_read_o[g]  = bus.mem_read;
        assign mem_write_o[g] = bus.mem_write;

        assign idx           = 6'((bus.mem_adr - 32'd1024) >> 2);
        assign bus.mem_rdata = mem[idx];

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | i;
            if (g == 0) mem[5] = 32'hDEADBEEF;
        end

        always @(negedge clk) begin
            if (bus.mem_write) mem[idx] = bus.mem_wdata;
        end
    end

    function automatic logic [31:0] word_init(input int i);
        return 32'hC0DE0000 | i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input int port, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            req0_i[inst] = r; we0_i[inst] = w; addr0_i[inst] = a; wdata0_i[inst] = d;
        end else begin
            req1_i[inst] = r; we1_i[inst] = w; addr1_i[inst] = a; wdata1_i[inst] = d;
        end
    endtask

    function automatic logic [31:0] outs_flat(input int inst);
        return {24'(0), ready0_o[inst], err0_o[inst], ready1_o[inst], err1_o[inst],
                mem_read_o[inst], mem_write_o[inst], 2'b00}
               | rdata_o[inst] | mem_adr_o[inst] | mem_wdata_o[inst];
    endfunction

    // Single transaction on one port; latency is counted from the IDLE cycle the request is presented in.
    task automatic run_txn(input int inst, input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd,
                           input string name);
        int          lat = 0;
        int          nrd = 0;
        int          nwr = 0;
        logic        got_err = 1'b0;
        logic        other = 1'b0;
        logic [31:0] got_rd = '0;
        logic [31:0] wr_adr = '0;
        int          wc = WCS[inst];
        @(posedge clk); #1;
        drive(inst, port, 1'b1, we, addr, wdata);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (mem_read_o[inst]) nrd++;
            if (mem_write_o[inst]) begin
                nwr++;
                wr_adr = mem_adr_o[inst];
            end
            if (port == 0) other |= ready1_o[inst] | err1_o[inst];
            else           other |= ready0_o[inst] | err0_o[inst];
            if ((port == 0) ? ready0_o[inst] : ready1_o[inst]) begin
                lat     = k;
                got_err = (port == 0) ? err0_o[inst] : err1_o[inst];
                got_rd  = rdata_o[inst];
            end
        end
        drive(inst, port, 1'b0, 1'b0, '0, '0);
        check({name, "_latency"}, lat, exp_err ? 1 : wc + 2);
        check({name, "_err"}, 32'(got_err), 32'(exp_err));
        check({name, "_other_port"}, 32'(other), 0);
        check({name, "_read_cycles"}, nrd, (exp_err || we) ? 0 : wc + 1);
        check({name, "_write_cycles"}, nwr, (exp_err || !we) ? 0 : 1);
        if (!exp_err && !we) check({name, "_rdata"}, got_rd, exp_rd);
        if (!exp_err && we)  check({name, "_write_adr"}, wr_adr, addr);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    function automatic vec_t mk(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic e, input logic [31:0] r, input string n);
        vec_t v;
        v.port = p; v.we = w; v.addr = a; v.wdata = d; v.exp_err = e; v.exp_rd = r; v.name = n;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int          order [4];
        logic [31:0] rds [4];
        int          nrdy;
        int          lat;
        int          first;
        logic [31:0] rd0;
        logic [31:0] rd1;

        vecs[0] = mk(0, 1'b0, 32'd1044, '0,            1'b0, 32'hDEADBEEF,  "rd_1044");
        vecs[1] = mk(1, 1'b1, 32'd1024, 32'h12345678,  1'b0, '0,            "wr_1024");
        vecs[2] = mk(1, 1'b0, 32'd1024, '0,            1'b0, 32'h12345678,  "rdback_1024");
        vecs[3] = mk(0, 1'b0, 32'd1280, '0,            1'b1, '0,            "err_1280");
        vecs[4] = mk(0, 1'b0, 32'd1026, '0,            1'b1, '0,            "err_1026");
        vecs[5] = mk(0, 1'b1, 32'd1020, 32'hFFFFFFFF,  1'b1, '0,            "err_1020");
        vecs[6] = mk(1, 1'b0, 32'd1276, '0,            1'b0, word_init(63), "rd_1276_top");
        vecs[7] = mk(1, 1'b1, 32'd1023, 32'h11111111,  1'b1, '0,            "err_1023");

        for (int i = 0; i < 3; i++) begin
            drive(i, 0, 1'b0, 1'b0, '0, '0);
            drive(i, 1, 1'b0, 1'b0, '0, '0);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_outputs_%0d", i), outs_flat(i), 0);
        rst = 1'b1;

        // Contention from reset on instance 0: both held for four transactions.
        @(posedge clk); #1;
        drive(0, 0, 1'b1, 1'b0, 32'd1032, '0);
        drive(0, 1, 1'b1, 1'b0, 32'd1036, '0);
        nrdy = 0;
        for (int k = 0; k < 60 && nrdy < 4; k++) begin
            @(posedge clk); #1;
            if (ready0_o[0] || ready1_o[0]) begin
                order[nrdy] = ready1_o[0] ? 1 : 0;
                rds[nrdy]   = rdata_o[0];
                nrdy++;
            end
        end
        drive(0, 0, 1'b0, 1'b0, '0, '0);
        drive(0, 1, 1'b0, 1'b0, '0, '0);
        check("contention_count", nrdy, 4);
        for (int i = 0; i < nrdy; i++) begin
            check($sformatf("contention_order_%0d", i), order[i], i % 2);
            check($sformatf("contention_rdata_%0d", i), rds[i], word_init((i % 2 == 0) ? 2 : 3));
        end

        for (int i = 0; i < 8; i++) begin
            run_txn(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_err, vecs[i].exp_rd, vecs[i].name);
        end

        // Request dropped and inputs changed after latching: the latched write still completes.
        @(posedge clk); #1;
        drive(0, 0, 1'b1, 1'b1, 32'd1048, 32'h5A5A0001);
        @(posedge clk); #1;
        drive(0, 0, 1'b0, 1'b0, 32'd1052, 32'hFFFFFFFF);
        lat = 0;
        for (int k = 2; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ready0_o[0]) lat = k;
        end
        check("drop_latency", lat, 3);
        check("drop_word6", g_inst[0].mem[6], 32'h5A5A0001);
        check("drop_word7", g_inst[0].mem[7], word_init(7));

        // WAIT_CYCLES=0 instance.
        run_txn(2, 0, 1'b0, 32'd1060, '0, 1'b0, word_init(9), "wc0_rd");
        run_txn(2, 1, 1'b1, 32'd1064, 32'h0BADF00D, 1'b0, '0, "wc0_wr");
        run_txn(2, 0, 1'b0, 32'd1064, '0, 1'b0, 32'h0BADF00D, "wc0_rdback");

        // WAIT_CYCLES=3 instance: leave last_grant at 0, then reset during a write from port 1.
        run_txn(1, 0, 1'b0, 32'd1032, '0, 1'b0, word_init(2), "wc3_rd");
        @(posedge clk); #1;
        drive(1, 1, 1'b1, 1'b1, 32'd1028, 32'hAAAAAAAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset_outputs", outs_flat(1), 0);
        drive(1, 1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("midreset_word1", g_inst[1].mem[1], word_init(1));
        rst = 1'b1;

        @(posedge clk); #1;
        drive(1, 0, 1'b1, 1'b0, 32'd1036, '0);
        drive(1, 1, 1'b1, 1'b0, 32'd1040, '0);
        first = -1;
        nrdy = 0;
        rd0 = '0;
        rd1 = '0;
        for (int k = 0; k < 60 && nrdy < 2; k++) begin
            @(posedge clk); #1;
            if (ready0_o[1]) begin
                if (first < 0) first = 0;
                rd0 = rdata_o[1];
                drive(1, 0, 1'b0, 1'b0, '0, '0);
                nrdy++;
            end
            if (ready1_o[1]) begin
                if (first < 0) first = 1;
                rd1 = rdata_o[1];
                drive(1, 1, 1'b0, 1'b0, '0, '0);
                nrdy++;
            end
        end
        drive(1, 0, 1'b0, 1'b0, '0, '0);
        drive(1, 1, 1'b0, 1'b0, '0, '0);
        check("postreset_count", nrdy, 2);
        check("postreset_first_grant", first, 0);
        check("postreset_rdata0", rd0, word_init(3));
        check("postreset_rdata1", rd1, word_init(4));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer for the word-addressed data memory, which has a negedge write, a combinational read, and a window at byte addresses 1024..1279.
- Shares the memory between requester 0 (pipeline MEM stage) and requester 1 (DMA/debug port) using round-robin grant.
- Holds the memory-side address and data stable for a programmable number of wait cycles, then returns a one-cycle ready pulse with read data to the winning requester.
- Range and alignment checks happen before any memory access.

Parameters:
- BASE_ADDR, 1024: first valid byte address of the data memory window.
- WORD_COUNT, 64: number of 32-bit words in the memory.
- WAIT_CYCLES, 1: extra cycles the ACCESS state is held (0..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; one clock domain.
- req0  in  1  requester 0 transaction request; held until ready0.
- we0  in  1  requester 0 write enable (1 = write, 0 = read).
- addr0  in  32  requester 0 byte address.
- wdata0  in  32  requester 0 write data.
- ready0  out  1  one-cycle completion pulse to requester 0.
- err0  out  1  valid with ready0: address out of range or misaligned.
- req1, we1, addr1, wdata1, ready1, err1: same as the requester 0 ports, for requester 1.
- rdata  out  32  read data, valid while ready0 or ready1 is high.
- mem_adr  out  32  byte address to the memory.
- mem_wdata  out  32  write data to the memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  32  combinational read data from the memory.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; last_grant=1, so requester 0 wins first. ready*, err*, mem_read, mem_write are 0. rdata, mem_adr, mem_wdata are 0. The wait counter is 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Choose a winner. With both requests high, the winner is the requester not equal to last_grant; with one request high, that requester wins.
  - Latch the winner's id, we, addr and wdata into internal registers.
  - Range check: addr < BASE_ADDR, addr >= BASE_ADDR+4*WORD_COUNT, or addr[1:0] != 0 sets the err flag and goes to DONE. No memory strobe is issued.
  - Otherwise load cnt=WAIT_CYCLES and go to ACCESS.
- ACCESS:
  - mem_adr and mem_wdata are driven from the latched registers and stay stable for the whole state.
  - Read: mem_read=1 throughout the state.
  - Write: mem_write=1 only in the final cycle (cnt==0), so exactly one negedge write occurs.
  - While cnt != 0, decrement cnt.
  - When cnt==0: register mem_rdata into rdata (reads only) and go to DONE.
- DONE:
  - Assert ready of the latched id for exactly 1 cycle, with err registered alongside it.
  - Set last_grant=id and return to IDLE.
  - The other requester's ready and err stay 0.
- Latency: a request seen in IDLE at cycle t gives ready at t+WAIT_CYCLES+2. An error gives ready at t+1.
- Back-to-back: a requester that holds req high after ready is re-arbitrated in the next IDLE cycle.
  - With both requests held continuously, grants alternate 0,1,0,1.
  - IDLE lasts at least 1 cycle between transactions.
- Request dropped mid-transaction: the transaction still completes and ready still pulses; the latched values are authoritative.
- Input changes after latching (addr/wdata/we) are ignored.
- Simultaneous new request during ACCESS/DONE: it waits and is arbitrated in the next IDLE.
- Reset asserted mid-ACCESS:
  - All outputs drop to their reset values immediately.
  - mem_write=0 asynchronously, so no partial write is committed after reset assertion.
- Arithmetic: range compare is unsigned 32-bit. Upper bound = BASE_ADDR + (WORD_COUNT<<2), computed as a 32-bit constant.
- cnt is 4 bits wide.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - DMEM_BASE=1024;
  - DMEM_WORDS=64;
  - function in_range(addr) returning the range/alignment check.
- Sub-module rr_arb2:
  - Combinational two-way round-robin pick.
  - Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_id.
  - Instantiated once in dmem_arbiter.

Test Plan:
- Read, WAIT_CYCLES=1: memory word 5 preset to 32'hDEADBEEF; req0 read addr0=1044. Required: mem_read high for 2 cycles, ready0 pulses at t+3 with rdata=32'hDEADBEEF, err0=0, ready1 stays 0.
- Write then read: req1 write addr1=1024, wdata1=32'h12345678. Required: mem_write high for exactly 1 cycle with mem_adr=1024. A following req1 read of 1024 returns 32'h12345678.
- Contention: req0 and req1 both held high for 4 transactions from reset. Required: ready pulse order 0,1,0,1; each read returns its own address's data.
- Errors:
  - addr0=1280 → ready0 at t+1 with err0=1.
  - addr0=1026 → same response.
  - addr0=1020 → same response.
  - No mem_read or mem_write is asserted for any of these.
- Reset mid-ACCESS: WAIT_CYCLES=3, write to 1028 of 32'hAAAAAAAA; pull rst low on the 2nd ACCESS cycle. Required: outputs go to 0 immediately; word 1 is unchanged; after release, the next req0 is granted first.
- WAIT_CYCLES=0: single read. Required: ACCESS lasts 1 cycle and ready0 arrives at t+2.
